seq_ring_gen: RTL and testbench

- Synchronous one-hot timing-phase generator for the 8-bit processor control path.
- Produces the instruction-cycle phase signals wseq[NUM_PHASES-1:0].
- Bits 2..6 feed the inverter-chain delay stage directly downstream, which produces the dwseq skew copies.
- Supports run, halt-at-cycle-end, early instruction termination and single-step, and counts completed instruction cycles.

---
 rtl/seq_ring_gen.sv | 95 +++++++++
 tb/tb_seq_ring_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_ring_gen.sv
// One-hot instruction-cycle phase generator with run/halt/step control
// and a count of completed instruction cycles.
module seq_ring_gen #(
   parameter int NUM_PHASES = 7,
   parameter int PH_W       = 3,
   parameter int CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  halt_req,
   input  logic                  early_end,
   input  logic                  step_en,
   input  logic                  step,
   output logic [NUM_PHASES-1:0] wseq,
   output logic [PH_W-1:0]       phase,
   output logic                  cycle_done,
   output logic                  running,
   output logic                  halted,
   output logic [CNT_W-1:0]      cycle_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

   logic [1:0] state;
   logic       halt_pending;
   logic       adv;
   logic       eoc;
   logic       do_halt;

   assign adv     = ~step_en | step;
   assign eoc     = adv & ((phase == LAST_PH) | early_end);
   assign do_halt = halt_req | halt_pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         wseq         <= '0;
         phase        <= '0;
         cycle_done   <= 1'b0;
         running      <= 1'b0;
         halted       <= 1'b0;
         cycle_count  <= '0;
         halt_pending <= 1'b0;
      end else begin
         cycle_done <= 1'b0;
         unique case (1'b1)
            (state == S_RUN): begin
               if (halt_req)
                  halt_pending <= 1'b1;
               if (eoc) begin
                  cycle_done  <= 1'b1;
                  cycle_count <= cycle_count + CNT_W'(1);
                  phase       <= '0;
                  if (do_halt) begin
                     // halt only ever lands on a cycle boundary
                     state        <= S_HALT;
                     wseq         <= '0;
                     running      <= 1'b0;
                     halted       <= 1'b1;
                     halt_pending <= 1'b0;
                  end else begin
                     wseq <= NUM_PHASES'(1);
                  end
               end else if (adv) begin
                  phase <= phase + PH_W'(1);
                  wseq  <= wseq << 1;
               end
            end
            (state == S_IDLE),
            (state == S_HALT): begin
               if (start) begin
                  state   <= S_RUN;
                  phase   <= '0;
                  wseq    <= NUM_PHASES'(1);
                  running <= 1'b1;
                  halted  <= 1'b0;
               end
            end
            default: begin
               state   <= S_IDLE;
               wseq    <= '0;
               phase   <= '0;
               running <= 1'b0;
               halted  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_ring_gen.sv
// Bench for seq_ring_gen: directed vector table, multi-cycle corner
// sequences and random stimulus against a behavioural model.
module tb_seq_ring_gen;

   localparam int N = 7;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         halt_req = 1'b0;
   logic         early_end = 1'b0;
   logic         step_en = 1'b0;
   logic         step = 1'b0;
   logic [N-1:0] wseq;
   logic [2:0]   phase;
   logic         cycle_done;
   logic         running;
   logic         halted;
   logic [7:0]   cycle_count;

   seq_ring_gen #(.NUM_PHASES(N), .PH_W(3), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .early_end(early_end), .step_en(step_en), .step(step),
      .wseq(wseq), .phase(phase), .cycle_done(cycle_done),
      .running(running), .halted(halted), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // model: mode 0=idle 1=run 2=halt
   int mmode = 0;
   int mph   = 0;
   int mcnt  = 0;
   bit mpend = 0;
   bit mdone = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                    name, act, exp, $time);
   endtask

   task automatic model_edge(input bit r, s, h, e, se, sp);
      if (r) begin
         mmode = 0; mph = 0; mcnt = 0; mpend = 0; mdone = 0;
         return;
      end
      mdone = 0;
      if (mmode == 1) begin
         if (h) mpend = 1;
         if (!se || sp) begin
            if (mph == N - 1 || e) begin
               mdone = 1;
               mcnt  = (mcnt + 1) % 256;
               mph   = 0;
               if (mpend) begin
                  mmode = 2;
                  mpend = 0;
               end
            end else begin
               mph = mph + 1;
            end
         end
      end else if (s) begin
         mmode = 1;
         mph   = 0;
      end
   endtask

   task automatic cyc(input bit r, s, h, e, se, sp);
      logic [N-1:0] ew;
      rst = r; start = s; halt_req = h;
      early_end = e; step_en = se; step = sp;
      @(posedge clk);
      model_edge(r, s, h, e, se, sp);
      #1;
      ew = (mmode == 1) ? N'(1 << mph) : '0;
      chk("wseq", 32'(wseq), 32'(ew));
      chk("phase", 32'(phase), (mmode == 1) ? 32'(mph) : 32'd0);
      chk("cycle_done", 32'(cycle_done), 32'(mdone));
      chk("running", 32'(running), 32'(mmode == 1));
      chk("halted", 32'(halted), 32'(mmode == 2));
      chk("cycle_count", 32'(cycle_count), 32'(mcnt));
      chk("onehot", 32'($onehot0(wseq) && ((wseq != 0) == running)), 32'd1);
   endtask

   typedef struct {
      bit       r, s, h, e;
      bit [6:0] ew;
      bit       ed, erun, ehlt;
      bit [7:0] ecnt;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(bit r, s, h, e, bit [6:0] ew,
                               bit ed, erun, ehlt, bit [7:0] ecnt);
      vec_t v;
      v.r = r; v.s = s; v.h = h; v.e = e; v.ew = ew;
      v.ed = ed; v.erun = erun; v.ehlt = ehlt; v.ecnt = ecnt;
      return v;
   endfunction

   initial begin
      int steps_seen;
      int wrap_seen;
      logic [7:0] prev_cnt;
      logic [N-1:0] prev_w;

      // full cycle, early end at phase 3, halt pulse at phase 2, restart
      vt.push_back(mk(1,0,0,0, 7'h00, 0,0,0, 0));
      vt.push_back(mk(0,1,0,0, 7'h01, 0,1,0, 0));
      vt.push_back(mk(0,0,0,0, 7'h02, 0,1,0, 0));
      vt.push_back(mk(0,0,0,0, 7'h04, 0,1,0, 0));
      vt.push_back(mk(0,0,0,0, 7'h08, 0,1,0, 0));
      vt.push_back(mk(0,0,0,0, 7'h10, 0,1,0, 0));
      vt.push_back(mk(0,0,0,0, 7'h20, 0,1,0, 0));
      vt.push_back(mk(0,0,0,0, 7'h40, 0,1,0, 0));
      vt.push_back(mk(0,0,0,0, 7'h01, 1,1,0, 1));
      vt.push_back(mk(0,0,0,0, 7'h02, 0,1,0, 1));
      vt.push_back(mk(0,0,0,0, 7'h04, 0,1,0, 1));
      vt.push_back(mk(0,0,0,0, 7'h08, 0,1,0, 1));
      vt.push_back(mk(0,0,0,1, 7'h01, 1,1,0, 2));
      vt.push_back(mk(0,0,0,0, 7'h02, 0,1,0, 2));
      vt.push_back(mk(0,0,0,0, 7'h04, 0,1,0, 2));
      vt.push_back(mk(0,0,1,0, 7'h08, 0,1,0, 2));
      vt.push_back(mk(0,1,0,0, 7'h10, 0,1,0, 2));
      vt.push_back(mk(0,0,0,0, 7'h20, 0,1,0, 2));
      vt.push_back(mk(0,0,0,0, 7'h40, 0,1,0, 2));
      vt.push_back(mk(0,0,0,0, 7'h00, 1,0,1, 3));
      vt.push_back(mk(0,0,1,0, 7'h00, 0,0,1, 3));
      vt.push_back(mk(0,1,0,0, 7'h01, 0,1,0, 3));
      vt.push_back(mk(0,0,0,1, 7'h01, 1,1,0, 4));

      @(negedge clk);
      foreach (vt[i]) begin
         cyc(vt[i].r, vt[i].s, vt[i].h, vt[i].e, 1'b0, 1'b0);
         chk("tbl_wseq", 32'(wseq), 32'(vt[i].ew));
         chk("tbl_done", 32'(cycle_done), 32'(vt[i].ed));
         chk("tbl_run", 32'(running), 32'(vt[i].erun));
         chk("tbl_halt", 32'(halted), 32'(vt[i].ehlt));
         chk("tbl_cnt", 32'(cycle_count), 32'(vt[i].ecnt));
      end

      // single step: step every 3rd cycle
      cyc(1,0,0,0,0,0);
      cyc(0,1,0,0,1,0);
      steps_seen = 0;
      prev_w = wseq;
      for (int i = 0; i < 3 * N; i++) begin
         cyc(0,0,0,0,1,(i % 3) == 2);
         if (wseq != prev_w) steps_seen++;
         if (cycle_done) chk("step_done_at_end", 32'(i), 32'(3 * N - 1));
         prev_w = wseq;
      end
      chk("step_moves", 32'(steps_seen), 32'(N));
      chk("step_cnt", 32'(cycle_count), 32'd1);

      // reset at phase 4 with halt pending
      cyc(0,0,0,0,0,0);
      cyc(0,0,1,0,0,0);
      cyc(0,0,0,0,0,0);
      cyc(0,0,0,0,0,0);
      chk("pre_rst_wseq", 32'(wseq), 32'h10);
      cyc(1,0,0,0,0,0);
      chk("rst_wseq", 32'(wseq), 32'd0);
      chk("rst_cnt", 32'(cycle_count), 32'd0);
      cyc(0,1,0,0,0,0);
      for (int i = 0; i < N; i++) cyc(0,0,0,0,0,0);
      chk("no_stale_halt", 32'(running && !halted && wseq == 1), 32'd1);

      // 256 full cycles: counter wrap
      cyc(1,0,0,0,0,0);
      cyc(0,1,0,0,0,0);
      wrap_seen = 0;
      prev_cnt = cycle_count;
      for (int i = 0; i < 256 * N; i++) begin
         cyc(0,0,0,0,0,0);
         if (prev_cnt == 8'd255 && cycle_count == 8'd0) wrap_seen++;
         prev_cnt = cycle_count;
      end
      chk("wrap_seen", 32'(wrap_seen), 32'd1);
      chk("wrap_cnt", 32'(cycle_count), 32'd0);

      // random stimulus
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 99) == 0,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 7) == 0,
             (i / 500) % 2 == 1,
             $urandom_range(0, 2) == 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
